mips_store_buffer: RTL
======================

# mips_store_buffer

Posted-write store buffer between the MIPS datapath's memory stage and data memory: the register-to-memory direction of the datapath, opposite to the memory-to-register writeback select. It accepts word stores from the pipeline in one cycle, queues them in a small FIFO, and drains them to data memory under a we/ack handshake. It also forwards the newest buffered data to loads that hit a pending address, so loads never read stale memory.

## Interface

- DEPTH, 4, number of buffered stores; power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  pipeline presents a store this cycle
- st_addr  in  32  store byte address; bits [1:0] ignored (word stores)
- st_data  in  32  store data
- st_ready  out  1  buffer can accept; equals !full
- ld_addr  in  32  load address for forwarding check; bits [1:0] ignored
- ld_hit  out  1  some buffered entry matches ld_addr[31:2]
- ld_data  out  32  data of newest matching entry; 0 when !ld_hit
- mem_we  out  1  write request to data memory (registered)
- mem_addr  out  32  head entry address, {addr[31:2],2'b00}
- mem_wdata  out  32  head entry data
- mem_ack  in  1  memory accepted the current write this cycle
- count  out  $clog2(DEPTH)+1  entries held
- empty  out  1  count==0
- full  out  1  count==DEPTH

## Operation

- Storage: circular FIFO of DEPTH entries {addr[31:2], data}; head and tail pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH; separate count register.
- Push: st_valid && st_ready at a rising edge writes entry at tail, tail+1, count+1. st_valid while full is ignored (no capture, no error); the pipeline must hold the store.
- No bypass: a store pushed into an empty buffer is still written at the tail and drained normally; st_ready does not depend on mem_ack in the same cycle.
- Drain FSM, two states:
  - IDLE: mem_we=0. If count!=0 at a rising edge → WRITE.
  - WRITE: mem_we=1, mem_addr/mem_wdata from head. On edge with mem_ack=1: pop (head+1, count-1); if count after pop and push is 0 → IDLE, else stay WRITE with the next head. mem_ack=0: hold all outputs stable.
- mem_ack while IDLE is ignored.
- Simultaneous push and pop: count unchanged, both pointers advance. When full, a pop does not raise st_ready within the same cycle; the freed slot is available the next cycle.
- Forwarding (combinational): compare ld_addr[31:2] with every valid entry; when several match, the most recently pushed wins. The entry being pushed this cycle is not compared. An entry popped at the end of this cycle is still compared during this cycle.
- Stores to the same address are kept as separate entries and drained in order; no coalescing.

## Timing

- Reset (asynchronous, immediate): FSM IDLE, mem_we=0, head=tail=0, count=0, empty=1, full=0, st_ready=1, ld_hit=0, ld_data=0. mem_addr/mem_wdata are 0 with an empty buffer. Reset mid-write drops all pending stores; no partial write is retried.
- Latency: store accepted at edge N; count=1 after N; forwarding hit visible after N; mem_we=1 after edge N+1.
- Drain throughput with mem_ack held high: one write per cycle, back-to-back, mem_we stays 1.
- count, empty, full, and st_ready update only at rising edges. mem_addr/mem_wdata/ld_* follow storage combinationally.

## Test plan

- Reset mid-operation: fill 3 entries, stall mem_ack, assert rst_n=0 asynchronously mid-cycle → mem_we=0, count=0, st_ready=1 immediately; after release no write issues.
- Single store: push (0x0000_0010, 0xDEADBEEF) at edge 0, mem_ack=1 from edge 2 → mem_we=1 with addr 0x10/data 0xDEADBEEF after edge 1; after edge 2 mem_we=0, empty=1.
- Fill and wrap: mem_ack=0, push 5 stores at DEPTH=4 → the 5th is not accepted, full=1, st_ready=0. Then ack 4 times while pushing 4 more → writes emerge in push order across the pointer wrap; count never exceeds 4.
- Forwarding priority: push A=0x100/0x1, B=0x200/0x2, A=0x103/0x3 with mem_ack=0; ld_addr=0x100 → ld_hit=1, ld_data=0x3. ld_addr=0x300 → ld_hit=0, ld_data=0.
- Ack stall: hold mem_ack=0 for 10 cycles in WRITE → mem_we, mem_addr, and mem_wdata remain stable. One ack pops exactly one entry.
- Simultaneous push and pop at count=2 → count stays 2, order is preserved, and the next mem_addr is the former second entry.

Source files
------------

// File: rtl/mips_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mips_store_buffer
// Purpose  : Posted-write store buffer between the MIPS memory stage and data
//            memory. Word stores are queued in a circular FIFO and drained to
//            memory one at a time under a we/ack handshake. Loads that hit a
//            buffered address get the newest buffered data forwarded.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            st_valid_i/st_addr_i/st_data_i - store from pipeline
//            st_ready_o                     - buffer not full
//            ld_addr_i, ld_hit_o, ld_data_o - load forwarding lookup
//            mem_we_o/mem_addr_o/mem_wdata_o, mem_ack_i - memory write port
//            count_o, empty_o, full_o       - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module mips_store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid_i,
  input  logic [31:0]              st_addr_i,
  input  logic [31:0]              st_data_i,
  output logic                     st_ready_o,
  input  logic [31:0]              ld_addr_i,
  output logic                     ld_hit_o,
  output logic [31:0]              ld_data_o,
  output logic                     mem_we_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wdata_o,
  input  logic                     mem_ack_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [0:0]    state_q, state_d;

  logic          push;
  logic          pop;
  logic [PW-1:0] fwd_idx;

  // Byte-offset bits are meaningless for word stores/loads.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{st_addr_i[1:0], ld_addr_i[1:0]};

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign st_ready_o = ~full_o;
  assign count_o    = count_q;

  // Ready is taken from the registered count only, so a pop in the same
  // cycle never lets a store in while full.
  assign push = st_valid_i & ~full_o;
  // WRITE is only ever entered/held with at least one entry buffered.
  assign pop  = (state_q == S_WRITE) & mem_ack_i;

  assign head_d  = pop  ? head_q + PW'(1) : head_q;
  assign tail_d  = push ? tail_q + PW'(1) : tail_q;
  assign count_d = count_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != '0) state_d = S_WRITE;
      S_WRITE: if (pop && (count_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_we_o    = (state_q == S_WRITE);
  assign mem_addr_o  = empty_o ? 32'h0 : {addr_q[head_q], 2'b00};
  assign mem_wdata_o = empty_o ? 32'h0 : data_q[head_q];

  // Walk entries oldest to newest so a later match overrides an earlier one,
  // leaving the most recently pushed matching entry as the result.
  always_comb begin
    ld_hit_o  = 1'b0;
    ld_data_o = 32'h0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[fwd_idx] == ld_addr_i[31:2])) begin
        ld_hit_o  = 1'b1;
        ld_data_o = data_q[fwd_idx];
      end
    end
  end

  // Storage needs no reset: every read path is qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= st_addr_i[31:2];
      data_q[tail_q] <= st_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= S_IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire
